// File: rtl/trap_sequencer.sv
// trap_sequencer: turns exceptions, timer interrupts, mret and CSR-instruction
// writes into a sequence of single-port CSR-file accesses, ending with a
// fetch redirect for traps and mret.
module trap_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [DATA_WIDTH-1:0] exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  mret_valid,
    input  logic                  irq,
    input  logic [DATA_WIDTH-1:0] cur_pc,
    input  logic                  csr_req_valid,
    output logic                  csr_req_ready,
    input  logic [11:0]           csr_req_addr,
    input  logic [DATA_WIDTH-1:0] csr_req_wdata,
    output logic                  csr_wen,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, M_EPC, M_STATUS, CSR_WR, REDIRECT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_epc;
    logic [DATA_WIDTH-1:0] r_cause;
    logic [11:0]           r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic [DATA_WIDTH-1:0] r_redirect_pc;

    logic                  w_wen;
    logic [11:0]           w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_ready;
    logic                  w_redir_valid;
    logic                  w_ld_exc;
    logic                  w_ld_irq;
    logic                  w_ld_req;
    logic                  w_ld_rpc;
    logic [DATA_WIDTH-1:0] w_rpc_val;
    logic                  w_irq_take;
    logic [DATA_WIDTH-1:0] w_irq_cause;
    logic [DATA_WIDTH-1:0] w_status_trap;
    logic [DATA_WIDTH-1:0] w_status_mret;

    // Interrupt cause code and the two mstatus rewrites, all derived from the
    // current CSR read (mstatus is on the port whenever these are used).
    always_comb begin
        w_irq_cause                 = '0;
        w_irq_cause[DATA_WIDTH-1]   = 1'b1;
        w_irq_cause[2:0]            = 3'd7;
        w_status_trap               = csr_rdata;
        w_status_trap[7]            = csr_rdata[3];
        w_status_trap[3]            = 1'b0;
        w_status_trap[12:11]        = 2'b11;
        w_status_mret               = csr_rdata;
        w_status_mret[3]            = csr_rdata[7];
        w_status_mret[7]            = 1'b1;
        w_status_mret[12:11]        = 2'b11;
        w_irq_take                  = irq & csr_rdata[3];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode, CSR port drive and load enables for the datapath.
    always_comb begin
        w_next        = r_state;
        w_wen         = 1'b0;
        w_addr        = '0;
        w_wdata       = '0;
        w_ready       = 1'b0;
        w_redir_valid = 1'b0;
        w_ld_exc      = 1'b0;
        w_ld_irq      = 1'b0;
        w_ld_req      = 1'b0;
        w_ld_rpc      = 1'b0;
        w_rpc_val     = '0;
        case (r_state)
            IDLE: begin
                // mstatus stays on the read port so MIE can gate irq.
                w_addr = CSR_MSTATUS;
                if (exc_valid) begin
                    w_ld_exc = 1'b1;
                    w_next   = T_EPC;
                end else if (mret_valid) begin
                    w_next   = M_EPC;
                end else if (w_irq_take) begin
                    w_ld_irq = 1'b1;
                    w_next   = T_EPC;
                end else begin
                    w_ready = 1'b1;
                    if (csr_req_valid) begin
                        w_ld_req = 1'b1;
                        w_next   = CSR_WR;
                    end
                end
            end
            T_EPC: begin
                w_wen   = 1'b1;
                w_addr  = CSR_MEPC;
                w_wdata = r_epc;
                w_next  = T_CAUSE;
            end
            T_CAUSE: begin
                w_wen   = 1'b1;
                w_addr  = CSR_MCAUSE;
                w_wdata = r_cause;
                w_next  = T_STATUS;
            end
            T_STATUS: begin
                w_wen   = 1'b1;
                w_addr  = CSR_MSTATUS;
                w_wdata = w_status_trap;
                w_next  = T_VEC;
            end
            T_VEC: begin
                // Direct mode only: mode bits are dropped from the vector.
                w_addr    = CSR_MTVEC;
                w_ld_rpc  = 1'b1;
                w_rpc_val = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                w_next    = REDIRECT;
            end
            M_EPC: begin
                w_addr    = CSR_MEPC;
                w_ld_rpc  = 1'b1;
                w_rpc_val = csr_rdata;
                w_next    = M_STATUS;
            end
            M_STATUS: begin
                w_wen   = 1'b1;
                w_addr  = CSR_MSTATUS;
                w_wdata = w_status_mret;
                w_next  = REDIRECT;
            end
            CSR_WR: begin
                w_wen   = 1'b1;
                w_addr  = r_req_addr;
                w_wdata = r_req_wdata;
                w_next  = IDLE;
            end
            REDIRECT: begin
                w_redir_valid = 1'b1;
                if (redirect_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latched trap/request/redirect data; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc         <= '0;
            r_cause       <= '0;
            r_req_addr    <= '0;
            r_req_wdata   <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_ld_exc) begin
                r_epc   <= exc_pc;
                r_cause <= exc_cause;
            end
            if (w_ld_irq) begin
                r_epc   <= cur_pc;
                r_cause <= w_irq_cause;
            end
            if (w_ld_req) begin
                r_req_addr  <= csr_req_addr;
                r_req_wdata <= csr_req_wdata;
            end
            if (w_ld_rpc) r_redirect_pc <= w_rpc_val;
        end
    end

    // Reset blocks writes, handshakes and redirects in the cycle it is asserted.
    always_comb begin
        csr_wen        = w_wen & ~rst;
        csr_req_ready  = w_ready & ~rst;
        redirect_valid = w_redir_valid & ~rst;
        csr_addr       = w_addr;
        csr_wdata      = w_wdata;
        redirect_pc    = r_redirect_pc;
        busy           = (r_state != IDLE);
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed, table-driven bench for trap_sequencer with a small CSR file.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_valid, irq;
    logic [31:0] exc_cause, exc_pc, cur_pc;
    logic        csr_req_valid, csr_req_ready;
    logic [11:0] csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        busy;

    trap_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .mret_valid(mret_valid), .irq(irq), .cur_pc(cur_pc),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
        .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // CSR file the sequencer drives.
    logic [31:0] m_status = 32'h0000_0008;
    logic [31:0] m_tvec   = 32'h8000_0103;
    logic [31:0] m_epc    = 32'h0;
    logic [31:0] m_cause  = 32'h0;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wen) begin
            case (csr_addr)
                12'h300: m_status <= csr_wdata;
                12'h305: m_tvec   <= csr_wdata;
                12'h341: m_epc    <= csr_wdata;
                12'h342: m_cause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        rst, exc, mret, irq, req;
        logic [11:0] raddr;
        logic [31:0] rwdata;
        logic        rr;
        logic        e_busy, e_wen;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_rdy;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic m, input logic i,
                                input logic q, input logic [11:0] qa, input logic [31:0] qd,
                                input logic rr, input logic b, input logic w,
                                input logic [11:0] a, input logic [31:0] d, input logic rv,
                                input logic [31:0] rpc, input logic rdy);
        vec_t v;
        v.rst = r; v.exc = e; v.mret = m; v.irq = i; v.req = q;
        v.raddr = qa; v.rwdata = qd; v.rr = rr;
        v.e_busy = b; v.e_wen = w; v.e_addr = a; v.e_wdata = d;
        v.e_rv = rv; v.e_rpc = rpc; v.e_rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", tag, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check just after.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; exc_valid = v.exc; mret_valid = v.mret; irq = v.irq;
        csr_req_valid = v.req; csr_req_addr = v.raddr; csr_req_wdata = v.rwdata;
        redirect_ready = v.rr;
        #1;
        n_vec++;
        chk("busy",      idx, {31'b0, busy},           {31'b0, v.e_busy});
        chk("csr_wen",   idx, {31'b0, csr_wen},        {31'b0, v.e_wen});
        chk("csr_addr",  idx, {20'b0, csr_addr},       {20'b0, v.e_addr});
        chk("csr_wdata", idx, csr_wdata,               v.e_wdata);
        chk("redir_vld", idx, {31'b0, redirect_valid}, {31'b0, v.e_rv});
        chk("redir_pc",  idx, redirect_pc,             v.e_rpc);
        chk("req_ready", idx, {31'b0, csr_req_ready},  {31'b0, v.e_rdy});
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; exc_valid = 0; mret_valid = 0; irq = 0; csr_req_valid = 0;
        csr_req_addr = 0; csr_req_wdata = 0; redirect_ready = 0;
        exc_pc = 32'h8000_0010; exc_cause = 32'd11; cur_pc = 32'h8000_0040;
        repeat (2) @(posedge clk);

        //            rst e m i q  raddr    rwdata        rr  busy wen addr     wdata         rv rpc           rdy
        // reset cycle with a pending request: nothing accepted
        tbl.push_back(mk(1,0,0,0,1, 12'h305, 32'h1,         0,  0,0, 12'h300, 32'h0,         0, 32'h0,         0));
        // everything at once with MIE=1: exception only
        tbl.push_back(mk(0,1,1,1,1, 12'h305, 32'h1,         0,  0,0, 12'h300, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(0,1,0,0,1, 12'h305, 32'h1,         0,  1,1, 12'h341, 32'h8000_0010, 0, 32'h0,         0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h342, 32'd11,        0, 32'h0,         0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h300, 32'h1880,      0, 32'h0,         0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,0, 12'h305, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         1,  1,0, 12'h000, 32'h0,         1, 32'h8000_0100, 0));
        // irq with MIE=0 is ignored
        tbl.push_back(mk(0,0,0,1,0, 12'h0,   32'h0,         0,  0,0, 12'h300, 32'h0,         0, 32'h8000_0100, 1));
        tbl.push_back(mk(0,0,0,1,0, 12'h0,   32'h0,         0,  0,0, 12'h300, 32'h0,         0, 32'h8000_0100, 1));
        // CSR write mepc=0x80000014 (irq still masked)
        tbl.push_back(mk(0,0,0,1,1, 12'h341, 32'h8000_0014, 0,  0,0, 12'h300, 32'h0,         0, 32'h8000_0100, 1));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h341, 32'h8000_0014, 0, 32'h8000_0100, 0));
        // mret with mstatus=0x1880
        tbl.push_back(mk(0,0,1,0,0, 12'h0,   32'h0,         0,  0,0, 12'h300, 32'h0,         0, 32'h8000_0100, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,0, 12'h341, 32'h0,         0, 32'h8000_0100, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h300, 32'h1888,      0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         1,  1,0, 12'h000, 32'h0,         1, 32'h8000_0014, 0));
        // MIE now set: timer interrupt traps
        tbl.push_back(mk(0,0,0,1,0, 12'h0,   32'h0,         0,  0,0, 12'h300, 32'h0,         0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h341, 32'h8000_0040, 0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h342, 32'h8000_0007, 0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,1, 12'h300, 32'h1880,      0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         0,  1,0, 12'h305, 32'h0,         0, 32'h8000_0014, 0));
        tbl.push_back(mk(0,0,0,0,0, 12'h0,   32'h0,         1,  1,0, 12'h000, 32'h0,         1, 32'h8000_0100, 0));

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

        // mtvec rewrite, then a trap whose redirect is stalled for three cycles
        apply(mk(0,0,0,0,1, 12'h305, 32'h8000_0200, 0, 0,0, 12'h300, 32'h0,          0, 32'h8000_0100, 1), 100);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,1, 12'h305, 32'h8000_0200,  0, 32'h8000_0100, 0), 101);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 0,0, 12'h300, 32'h0,          0, 32'h8000_0100, 1), 102);
        apply(mk(0,1,0,0,0, 12'h0,   32'h0,         0, 0,0, 12'h300, 32'h0,          0, 32'h8000_0100, 0), 103);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,1, 12'h341, 32'h8000_0010,  0, 32'h8000_0100, 0), 104);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,1, 12'h342, 32'd11,         0, 32'h8000_0100, 0), 105);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,1, 12'h300, 32'h1800,       0, 32'h8000_0100, 0), 106);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,0, 12'h305, 32'h0,          0, 32'h8000_0100, 0), 107);
        for (int k = 0; k < 3; k++)
            apply(mk(0,1,1,1,1, 12'h305, 32'h1,     0, 1,0, 12'h000, 32'h0,          1, 32'h8000_0200, 0), 108 + k);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         1, 1,0, 12'h000, 32'h0,          1, 32'h8000_0200, 0), 111);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 0,0, 12'h300, 32'h0,          0, 32'h8000_0200, 1), 112);

        // reset during T_CAUSE aborts the trap
        apply(mk(0,1,0,0,0, 12'h0,   32'h0,         0, 0,0, 12'h300, 32'h0,          0, 32'h8000_0200, 0), 200);
        apply(mk(0,0,0,0,0, 12'h0,   32'h0,         0, 1,1, 12'h341, 32'h8000_0010,  0, 32'h8000_0200, 0), 201);
        apply(mk(1,0,0,0,0, 12'h0,   32'h0,         0, 1,0, 12'h342, 32'd11,         0, 32'h8000_0200, 0), 202);
        for (int k = 0; k < 4; k++)
            apply(mk(0,0,0,0,0, 12'h0, 32'h0,       1, 0,0, 12'h300, 32'h0,          0, 32'h0,         1), 203 + k);

        // mstatus must still hold the value from the completed trap
        n_vec++;
        chk("mstatus_kept", 300, m_status, 32'h1800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the CSR data and PC.
REQ-002 SHALL have clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have exc_valid  in  1  synchronous exception request (ecall/illegal).
REQ-005 SHALL have exc_cause  in  DATA_WIDTH  mcause value for the exception.
REQ-006 SHALL have exc_pc  in  DATA_WIDTH  PC of the faulting instruction.
REQ-007 SHALL have mret_valid  in  1  mret request.
REQ-008 SHALL have irq  in  1  level-sensitive machine timer interrupt.
REQ-009 SHALL have cur_pc  in  DATA_WIDTH  PC to save on an interrupt.
REQ-010 SHALL have csr_req_valid/csr_req_ready  in/out  1  CSR-instruction write handshake.
REQ-011 SHALL have csr_req_addr  in  12  and csr_req_wdata  in  DATA_WIDTH  for the CSR-instruction write.
REQ-012 SHALL have csr_wen  out  1, csr_addr  out  12, csr_wdata  out  DATA_WIDTH  as the single CSR-file port.
REQ-013 SHALL have csr_rdata  in  DATA_WIDTH  combinational CSR read of csr_addr.
REQ-014 SHALL have redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  DATA_WIDTH  as the fetch redirect handshake.
REQ-015 SHALL have busy  out  1, high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, M_EPC, M_STATUS, CSR_WR, REDIRECT.
REQ-017 In IDLE: csr_addr=0x300, csr_wen=0; irq is taken only if csr_rdata[3] (MIE)=1.
REQ-018 IDLE priority, highest first: exc_valid > mret_valid > irq&MIE > csr_req_valid; only one event accepted per cycle, the others ignored.
REQ-019 csr_req_ready SHALL be 1 only in IDLE with no higher-priority event; on handshake, latch addr/data and go to CSR_WR.
REQ-020 CSR_WR: csr_wen=1 with the latched addr/data for one cycle, then IDLE.
REQ-021 Exception: latch epc=exc_pc, cause=exc_cause. Interrupt: latch epc=cur_pc, cause={1'b1, zeros, 7}, i.e. 0x80000007 at DATA_WIDTH=32. Both go to T_EPC.
REQ-022 T_EPC writes 0x341<=epc. T_CAUSE writes 0x342<=cause. Each takes one cycle.
REQ-023 T_STATUS writes 0x300 <= csr_rdata with bit7 (MPIE)=old bit3, bit3=0, bits12:11=2'b11.
REQ-024 T_VEC: csr_addr=0x305, no write; latch redirect_pc=csr_rdata with bits1:0 cleared; go to REDIRECT.
REQ-025 M_EPC: csr_addr=0x341, no write; latch redirect_pc=csr_rdata; go to M_STATUS.
REQ-026 M_STATUS writes 0x300 <= csr_rdata with bit3=old bit7, bit7=1, bits12:11=2'b11; go to REDIRECT.
REQ-027 REDIRECT: redirect_valid=1 with redirect_pc stable until redirect_ready=1; then go to IDLE on that edge.
REQ-028 Latency: trap accepted in cycle N -> redirect_valid in N+5; mret -> N+3.
REQ-029 All inputs except redirect_ready and csr_rdata SHALL be ignored outside IDLE; requesters retry.
REQ-030 csr_wen SHALL be 0 in IDLE, T_VEC, M_EPC and REDIRECT; csr_addr/csr_wdata SHALL be 0 when not otherwise specified, except in IDLE (REQ-017).

Reset
REQ-031 On rst: state=IDLE; redirect_valid=0, redirect_pc=0, csr_wen=0, csr_wdata=0, busy=0; latched epc/cause/request = 0.
REQ-032 rst mid-sequence SHALL abort with no further CSR writes; rst has priority over all events.
REQ-033 csr_req_ready SHALL be 0 during the rst cycle.

Verification
REQ-034 exc_valid=1, exc_pc=0x80000010, exc_cause=11, mstatus=0x8, mtvec=0x80000103 -> writes 0x341=0x80000010, 0x342=11, 0x300=0x1880 in successive cycles; redirect_pc=0x80000100 at N+5.
REQ-035 mret with mepc=0x80000014, mstatus=0x1880 -> redirect_pc=0x80000014 at N+3; 0x300 written 0x1888.
REQ-036 irq=1 with MIE=0 -> no action, busy=0; then set MIE -> trap with cause 0x80000007 and mepc=cur_pc.
REQ-037 exc_valid, mret_valid, irq(MIE=1) and csr_req_valid all asserted in one IDLE cycle -> exception only; csr_req_ready=0.
REQ-038 CSR write 0x305<=0x80000200 -> csr_wen pulse one cycle after the handshake; redirect_ready held 0 for 3 cycles in REDIRECT -> redirect_pc stable, busy=1.
REQ-039 rst asserted in T_CAUSE -> next cycle IDLE, no 0x300 write, redirect_valid never asserted.
